// File: rtl/cbus_arbiter_n_if.sv
// cbus request/response types and the bundled N-port channel seen by cbus_arbiter_n.
// The slave modport is the arbiter side; the master modport is the cache/bridge side.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Burst length encodings: beats minus one.
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN16 = 4'd15;

endpackage

interface cbus_arbiter_n_if #(
  parameter int NUM_PORTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  [NUM_PORTS-1:0] ireqs;
  cbus_resp_t [NUM_PORTS-1:0] iresps;
  cbus_req_t                  oreq;
  cbus_resp_t                 oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );
endinterface

// File: rtl/cbus_arbiter_n.sv
// N-port cbus arbiter: round-robin grant, locked until ready&&last, one IDLE cycle between bursts.
// Build option CBUS_ARB_FIXED_PRIO_EN: lowest port index always wins (round-robin pointer held at 0).
//
// state  | meaning
// S_IDLE | no grant; outputs zeroed; pick next master from valid requests
// S_BUSY | gnt_idx_q owns the downstream channel until ready&&last
module cbus_arbiter_n
  import cbus_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cbus_arbiter_n_if.slave       bus,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      gnt_idx_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_found;
  int                 scan_pos;

  // Scan from rr_ptr upward with explicit wrap so non-power-of-2 counts never index past NUM_PORTS-1.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_pos   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_pos = int'(rr_ptr_q) + i;
      if (scan_pos >= NUM_PORTS) scan_pos = scan_pos - NUM_PORTS;
      if (!cand_found && bus.ireqs[IDX_W'(scan_pos)].valid) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(scan_pos);
      end
    end
  end

`ifdef CBUS_ARB_FIXED_PRIO_EN
  assign rr_next = '0;
`else
  assign rr_next = (gnt_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (cand_found) begin
          state_d   = S_BUSY;
          gnt_idx_d = cand_idx;
        end
      end
      S_BUSY: begin
        if (bus.oresp.ready && bus.oresp.last) begin
          state_d  = S_IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Granted master is forwarded as-is, including a dropped valid; others see all-zero responses.
  always_comb begin
    bus.oreq   = '0;
    bus.iresps = '0;
    if (state_q == S_BUSY) begin
      bus.oreq              = bus.ireqs[gnt_idx_q];
      bus.iresps[gnt_idx_q] = bus.oresp;
    end
  end

  assign busy_o    = (state_q == S_BUSY);
  assign gnt_idx_o = gnt_idx_q;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Self-checking bench for cbus_arbiter_n with NUM_PORTS=3: directed scenarios plus randomized traffic
// checked against a burst-level reference model (current owner, rotating scan start).
module tb_cbus_arbiter_n;
  import cbus_pkg::*;

  localparam int N     = 3;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [IDX_W-1:0] gnt_idx;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  bit m_busy = 1'b0;
  int m_gnt  = 0;
  int m_rr   = 0;

  cbus_arbiter_n_if #(.NUM_PORTS(N)) bus ();

  cbus_arbiter_n #(.NUM_PORTS(N)) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .bus       (bus),
    .busy_o    (busy),
    .gnt_idx_o (gnt_idx)
  );

  always #5 clk = ~clk;

  function automatic int model_pick();
    int start;
`ifdef CBUS_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_rr;
`endif
    for (int k = 0; k < N; k++) begin
      automatic int p = (start + k) % N;
      if (bus.ireqs[p].valid) return p;
    end
    return -1;
  endfunction

  task automatic model_update();
    int c;
    if (rst) begin
      m_busy = 1'b0; m_gnt = 0; m_rr = 0;
    end else if (!m_busy) begin
      c = model_pick();
      if (c >= 0) begin m_busy = 1'b1; m_gnt = c; end
    end else if (bus.oresp.ready && bus.oresp.last) begin
      m_busy = 1'b0;
`ifdef CBUS_ARB_FIXED_PRIO_EN
      m_rr = 0;
`else
      m_rr = (m_gnt + 1) % N;
`endif
    end
  endtask

  function automatic cbus_req_t exp_oreq();
    return m_busy ? bus.ireqs[m_gnt] : '0;
  endfunction

  function automatic cbus_resp_t exp_resp(int p);
    return (m_busy && m_gnt == p) ? bus.oresp : '0;
  endfunction

  function automatic cbus_req_t rand_req(logic v);
    cbus_req_t r;
    r.valid    = v;
    r.is_write = 1'($urandom);
    r.size     = 3'($urandom);
    r.addr     = $urandom;
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = 4'($urandom);
    r.burst    = 2'($urandom);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ireqs = '0;
    bus.oresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.ireqs[0].valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_total++; if (bus.oreq.valid !== 1'b0) $display("FAIL reset_oreq_valid: got %0b want 0", bus.oreq.valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_total++; if (gnt_idx !== '0) $display("FAIL reset_gnt: got %0d want 0", gnt_idx); else n_pass++;
    end
    rst = 1'b0;
    #1;
    step();
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd0) $display("FAIL reset_first_grant: got busy=%0b gnt=%0d want busy=1 gnt=0", busy, gnt_idx); else n_pass++;
  endtask

  task automatic test_single_read();
    cbus_resp_t r;
    do_reset();
    bus.ireqs[1]       = '0;
    bus.ireqs[1].valid = 1'b1;
    bus.ireqs[1].addr  = 32'h8000_0040;
    bus.ireqs[1].len   = MLEN16;
    #1;
    n_total++; if (bus.oreq.valid !== 1'b0) $display("FAIL sr_idle_oreq: got valid=%0b want 0", bus.oreq.valid); else n_pass++;
    step();
    n_total++; if (bus.oreq.addr !== 32'h8000_0040 || bus.oreq.valid !== 1'b1) $display("FAIL sr_oreq_addr: got %h/%0b want 80000040/1", bus.oreq.addr, bus.oreq.valid); else n_pass++;
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd1) $display("FAIL sr_grant: got busy=%0b gnt=%0d want 1/1", busy, gnt_idx); else n_pass++;
    // last without ready must not end the burst
    bus.oresp = '{ready: 1'b0, last: 1'b1, data: 32'h0};
    step();
    n_total++; if (busy !== 1'b1) $display("FAIL sr_last_no_ready: got busy=%0b want 1", busy); else n_pass++;
    for (int b = 0; b < 16; b++) begin
      r = '{ready: 1'b1, last: (b == 15), data: $urandom};
      bus.oresp = r;
      #1;
      n_total++; if (bus.iresps[1] !== r) $display("FAIL sr_beat%0d_resp1: got %h want %h", b, bus.iresps[1], r); else n_pass++;
      n_total++; if (bus.iresps[0] !== '0 || bus.iresps[2] !== '0) $display("FAIL sr_beat%0d_others: got %h/%h want 0", b, bus.iresps[0], bus.iresps[2]); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL sr_beat%0d_busy: got %0b want 1", b, busy); else n_pass++;
      step();
    end
    bus.oresp = '0;
    bus.ireqs[1].valid = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL sr_done_busy: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    do_reset();
    for (int p = 0; p < N; p++) begin
      bus.ireqs[p] = rand_req(1'b1);
      bus.ireqs[p].len = MLEN1;
    end
    bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h1234};
    #1;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (busy !== 1'b0) $display("FAIL rr_idle%0d: got busy=%0b want 0", k, busy); else n_pass++;
      step();
      n_total++; if (busy !== 1'b1 || gnt_idx !== IDX_W'(order[k])) $display("FAIL rr_grant%0d: got busy=%0b gnt=%0d want 1/%0d", k, busy, gnt_idx, order[k]); else n_pass++;
      step();
    end
  endtask

  task automatic test_lock();
    logic [31:0] d;
    logic [3:0]  s;
    do_reset();
    bus.ireqs[0]          = '0;
    bus.ireqs[0].valid    = 1'b1;
    bus.ireqs[0].is_write = 1'b1;
    bus.ireqs[0].len      = MLEN4;
    #1;
    step();
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd0) $display("FAIL lock_grant: got busy=%0b gnt=%0d want 1/0", busy, gnt_idx); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      d = $urandom;
      s = 4'(b + 1);
      bus.ireqs[0].data   = d;
      bus.ireqs[0].strobe = s;
      if (b == 1) bus.ireqs[1] = rand_req(1'b1);
      bus.oresp = '{ready: 1'b1, last: (b == 3), data: 32'h0};
      #1;
      n_total++; if (bus.oreq.data !== d || bus.oreq.strobe !== s) $display("FAIL lock_beat%0d_wdata: got %h/%h want %h/%h", b, bus.oreq.data, bus.oreq.strobe, d, s); else n_pass++;
      n_total++; if (bus.iresps[1].ready !== 1'b0) $display("FAIL lock_beat%0d_p1_ready: got %0b want 0", b, bus.iresps[1].ready); else n_pass++;
      step();
    end
    bus.ireqs[0].valid = 1'b0;
    bus.oresp = '0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL lock_release: got busy=%0b want 0", busy); else n_pass++;
    step();
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd1) $display("FAIL lock_next_grant: got busy=%0b gnt=%0d want 1/1", busy, gnt_idx); else n_pass++;
  endtask

  task automatic test_wrap();
    int exp_last;
`ifdef CBUS_ARB_FIXED_PRIO_EN
    exp_last = 0;
`else
    exp_last = 2;
`endif
    do_reset();
    bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
    bus.ireqs[1] = rand_req(1'b1);
    #1;
    step();
    n_total++; if (gnt_idx !== 2'd1) $display("FAIL wrap_g1: got %0d want 1", gnt_idx); else n_pass++;
    bus.ireqs[1].valid = 1'b0;
    step();
    bus.ireqs[0] = rand_req(1'b1);
    #1;
    step();
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd0) $display("FAIL wrap_g0: got busy=%0b gnt=%0d want 1/0", busy, gnt_idx); else n_pass++;
    bus.ireqs[0].valid = 1'b0;
    step();
    bus.ireqs[0].valid = 1'b1;
    bus.ireqs[2] = rand_req(1'b1);
    #1;
    step();
    n_total++; if (gnt_idx !== IDX_W'(exp_last)) $display("FAIL wrap_after_rr: got %0d want %0d", gnt_idx, exp_last); else n_pass++;
    clear_inputs();
    step();
  endtask

  task automatic test_prio_and_reset();
    int order[4];
`ifdef CBUS_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 2, 0, 2};
`endif
    do_reset();
    bus.ireqs[0] = rand_req(1'b1); bus.ireqs[0].len = MLEN1;
    bus.ireqs[2] = rand_req(1'b1); bus.ireqs[2].len = MLEN1;
    bus.oresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
    #1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++; if (gnt_idx !== IDX_W'(order[k])) $display("FAIL prio_grant%0d: got %0d want %0d", k, gnt_idx, order[k]); else n_pass++;
      step();
    end
    bus.ireqs[2].valid = 1'b0;
    bus.ireqs[0].len = MLEN4;
    bus.oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0};
    #1;
    step();
    step();
    rst = 1'b1;
    #1;
    step();
    n_total++; if (busy !== 1'b0 || bus.oreq !== '0) $display("FAIL midreset_zero: got busy=%0b oreq=%h want 0/0", busy, bus.oreq); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus.oreq !== '0 || bus.iresps !== '0) $display("FAIL midreset_idle: got oreq=%h iresps=%h want 0", bus.oreq, bus.iresps); else n_pass++;
    step();
    n_total++; if (busy !== 1'b1 || gnt_idx !== 2'd0) $display("FAIL midreset_regrant: got busy=%0b gnt=%0d want 1/0", busy, gnt_idx); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++)
        bus.ireqs[p] = rand_req(($urandom_range(0, 3) != 0));
      bus.oresp = '{ready: 1'($urandom), last: ($urandom_range(0, 2) == 0), data: $urandom};
      rst = ($urandom_range(0, 79) == 0);
      #1;
      n_total++;
      if (busy !== m_busy || gnt_idx !== IDX_W'(m_gnt) || bus.oreq !== exp_oreq()) begin
        if (errs < 10) $display("FAIL rand_c%0d_oreq: got busy=%0b gnt=%0d oreq=%h want busy=%0b gnt=%0d oreq=%h",
                                c, busy, gnt_idx, bus.oreq, m_busy, m_gnt, exp_oreq());
        errs++;
      end else n_pass++;
      for (int p = 0; p < N; p++) begin
        n_total++;
        if (bus.iresps[p] !== exp_resp(p)) begin
          if (errs < 10) $display("FAIL rand_c%0d_resp%0d: got %h want %h", c, p, bus.iresps[p], exp_resp(p));
          errs++;
        end else n_pass++;
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_wrap();
    test_prio_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
